// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
//   Keeps the fetch PC, issues word reads to a synchronous instruction ROM
//   (1-cycle latency) and buffers returned words in a QDEPTH-entry queue so
//   decode can stall without losing fetches. A redirect from decode flushes
//   the queue, drops the wrong-path response and fetches the target at once.
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   i_IF_stall        decode pause; queue head is held
//   i_IF_redirect     branch/jump taken in decode this cycle
//   i_IF_target       redirect address (bits [1:0] ignored)
//   o_IF_imemReq      ROM read request this cycle
//   o_IF_imemAddr     ROM word address
//   i_IF_imemRData    ROM data, valid one cycle after the request
//   o_IF_valid        queue head holds a valid instruction
//   o_IF_pc/o_IF_inst PC and instruction word of the queue head
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_IF_stall,
    input  logic        i_IF_redirect,
    input  logic [31:0] i_IF_target,
    output logic        o_IF_imemReq,
    output logic [31:0] o_IF_imemAddr,
    input  logic [31:0] i_IF_imemRData,
    output logic        o_IF_valid,
    output logic [31:0] o_IF_pc,
    output logic [31:0] o_IF_inst
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q   [QDEPTH];
    logic [31:0]   inst_mem_q [QDEPTH];

    logic          valid_s;
    logic          deq_s;
    logic          enq_s;
    logic          issue_s;
    logic [31:0]   tgt_s;
    logic [CW:0]   occ_s;
    logic [CW:0]   lim_s;
    logic          tgt_unused_s;

    // Only the word address of a redirect target matters.
    assign tgt_unused_s = ^i_IF_target[1:0];

    // Handshake decode, issue decision and next-state computation.
    always_comb begin
        valid_s       = (count_q != {CW{1'b0}});
        deq_s         = valid_s & ~i_IF_stall & ~i_IF_redirect;
        enq_s         = inflight_q & ~i_IF_redirect;
        tgt_s         = {i_IF_target[31:2], 2'b00};
        // Space test rearranged as count+inflight < QDEPTH+deq to stay unsigned.
        occ_s         = {1'b0, count_q} + (CW + 1)'(inflight_q);
        lim_s         = QDEPTH_W + (CW + 1)'(deq_s);
        issue_s       = ~rst & (i_IF_redirect | (occ_s < lim_s));
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (i_IF_redirect) begin
            // Flush everything; the target is fetched this very cycle.
            fetch_pc_d    = tgt_s + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = tgt_s;
            count_d       = {CW{1'b0}};
            rd_ptr_d      = {PW{1'b0}};
            wr_ptr_d      = {PW{1'b0}};
        end else begin
            count_d  = count_q + CW'(enq_s) - CW'(deq_s);
            rd_ptr_d = rd_ptr_q + PW'(deq_s);
            wr_ptr_d = wr_ptr_q + PW'(enq_s);
            if (issue_s) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end else begin
                fetch_pc_d    = fetch_pc_q;
                inflight_d    = 1'b0;
                inflight_pc_d = inflight_pc_q;
            end
        end
    end

    // State registers and queue storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            count_q       <= {CW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0000_0000;
                inst_mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            if (enq_s) begin
                pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
                inst_mem_q[wr_ptr_q] <= i_IF_imemRData;
            end else begin
                pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
                inst_mem_q[wr_ptr_q] <= inst_mem_q[wr_ptr_q];
            end
        end
    end

    // Request address bypasses the redirect target combinationally.
    assign o_IF_imemReq  = issue_s;
    assign o_IF_imemAddr = i_IF_redirect ? tgt_s : fetch_pc_q;
    assign o_IF_valid    = valid_s;
    assign o_IF_pc       = valid_s ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
    assign o_IF_inst     = valid_s ? inst_mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QD       = 2;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        stall  = 1'b0;
    logic        redir  = 1'b0;
    logic [31:0] tgt    = 32'h0;
    logic [31:0] rdata  = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_IF_stall     (stall),
        .i_IF_redirect  (redir),
        .i_IF_target    (tgt),
        .o_IF_imemReq   (req),
        .o_IF_imemAddr  (addr),
        .i_IF_imemRData (rdata),
        .o_IF_valid     (valid),
        .o_IF_pc        (pc),
        .o_IF_inst      (inst)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: contents are address ^ KEY.
    always @(posedge clk) if (req) rdata <= addr ^ KEY;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of delivered instructions ----
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc = RESET_PC;
    logic [31:0] m_ipc = 32'h0;
    bit          m_inf = 1'b0;

    function automatic bit m_deq();
        return (mq.size() != 0) && !stall && !redir;
    endfunction

    function automatic bit m_req();
        int room;
        room = QD - mq.size() + int'(m_deq()) - int'(m_inf);
        return redir || (room > 0);
    endfunction

    function automatic logic [31:0] m_addr();
        return redir ? (tgt & 32'hFFFF_FFFC) : m_fpc;
    endfunction

    always @(posedge rst) begin
        mq.delete();
        m_fpc = RESET_PC;
        m_inf = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_fpc = RESET_PC;
            m_inf = 1'b0;
        end else if (redir) begin
            mq.delete();
            m_ipc = tgt & 32'hFFFF_FFFC;
            m_fpc = m_ipc + 32'd4;
            m_inf = 1'b1;
        end else begin
            bit d, r;
            d = m_deq();
            r = m_req();
            if (d) void'(mq.pop_front());
            if (m_inf) mq.push_back('{m_ipc, m_ipc ^ KEY});
            if (r) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd4;
                m_inf = 1'b1;
            end else begin
                m_inf = 1'b0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", {31'h0, valid}, 32'h0);
            chk("rst_pc", pc, 32'h0);
            chk("rst_inst", inst, 32'h0);
            chk("rst_req", {31'h0, req}, 32'h0);
        end else begin
            chk("valid", {31'h0, valid}, {31'h0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("pc", pc, mq[0].pc);
                chk("inst", inst, mq[0].inst);
            end
            chk("req", {31'h0, req}, {31'h0, m_req()});
            if (m_req()) chk("addr", addr, m_addr());
            chk("count", 32'(dut.count_q), 32'(mq.size()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("t1_rst_valid", {31'h0, valid}, 32'h0);
        chk("t1_rst_req", {31'h0, req}, 32'h0);
        // Test 1: reset release, cycle 0
        rst = 1'b0;
        #1;
        chk("t1_req0", {31'h0, req}, 32'h1);
        chk("t1_addr0", addr, 32'h0);
        step(); #1; chk("t1_c1_valid", {31'h0, valid}, 32'h0);
        step(); #1; chk("t1_c2_valid", {31'h0, valid}, 32'h1);
        chk("t1_c2_pc", pc, 32'h0);
        chk("t1_c2_inst", inst, 32'hA5A5_0000);
        step(); #1; chk("t1_c3_pc", pc, 32'h4);
        chk("t1_c3_inst", inst, 32'hA5A5_0004);
        // Test 2: stall 5 cycles with head 8
        step(); stall = 1'b1; #1; chk("t2_c4_pc", pc, 32'h8);
        step();
        step(); #1;
        chk("t2_full_req", {31'h0, req}, 32'h0);
        chk("t2_full_cnt", 32'(dut.count_q), 32'd2);
        chk("t2_hold_pc", pc, 32'h8);
        step();
        step();
        step(); stall = 1'b0; #1;
        chk("t2_rel_pc", pc, 32'h8);
        chk("t2_rel_addr", addr, 32'h10);
        // Test 3: redirect to 0x40 while head is 0xC
        step(); redir = 1'b1; tgt = 32'h40; #1;
        chk("t3_head", pc, 32'hC);
        chk("t3_addr", addr, 32'h40);
        step(); redir = 1'b0; #1; chk("t3_bubble", {31'h0, valid}, 32'h0);
        step(); #1; chk("t3_pc40", pc, 32'h40);
        step(); #1; chk("t3_pc44", pc, 32'h44);
        // Test 4: redirect under stall, unaligned target
        stall = 1'b1; redir = 1'b1; tgt = 32'h43; #1;
        chk("t4_addr", addr, 32'h40);
        chk("t4_req", {31'h0, req}, 32'h1);
        step(); redir = 1'b0;
        step(); #1;
        chk("t4_pc", pc, 32'h40);
        chk("t4_inst", inst, 32'hA5A5_0040);
        stall = 1'b0;
        // Test 5: back-to-back redirects
        step(); redir = 1'b1; tgt = 32'h80;
        step(); tgt = 32'h100; #1;
        chk("t5_addr", addr, 32'h100);
        chk("t5_valid", {31'h0, valid}, 32'h0);
        step(); redir = 1'b0; #1; chk("t5_bubble", {31'h0, valid}, 32'h0);
        step(); #1; chk("t5_pc100", pc, 32'h100);
        step(); #1; chk("t5_pc104", pc, 32'h104);
        // Test 6: random run with an asynchronous reset pulse in the middle
        for (int i = 0; i < 2000; i++) begin
            step();
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                tgt = $urandom;
            if (i == 1000) begin
                redir = 1'b0;
                #1 rst = 1'b1;
                #1;
                chk("t6_async_valid", {31'h0, valid}, 32'h0);
                chk("t6_async_req", {31'h0, req}, 32'h0);
                rst = 1'b0;
                #1;
                chk("t6_restart_req", {31'h0, req}, 32'h1);
                chk("t6_restart_addr", addr, RESET_PC);
            end
        end
        step();
        redir = 1'b0;
        stall = 1'b0;
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
